// File: rtl/mix_pkg.sv
// mix_pkg: shared types and helpers for the saturating mixer and its
// shift+saturate stage.
//   state_t     : mixer FSM states (IDLE, ACCUM, SAT)
//   accWidth()  : accumulator width that cannot overflow for nch channels
//   satHi/satLo : signed saturation limits for an outW-bit result
package mix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2
  } state_t;

  // One extra bit beyond the channel-count growth keeps the sign intact.
  function automatic int accWidth(input int inW, input int nch);
    return inW + $clog2(nch) + 1;
  endfunction

  function automatic longint satHi(input int outW);
    return (longint'(1) <<< (outW - 1)) - longint'(1);
  endfunction

  function automatic longint satLo(input int outW);
    return -(longint'(1) <<< (outW - 1));
  endfunction

endpackage

// File: rtl/mix_accum_clip_if.sv
// mix_accum_clip_if: request/result bundle of the mixer.
//   iStart/iIn/iMask/iClrClip : driven by the master (voice side)
//   oBusy/oValid/oOut/oClip/oClipSticky/oClipCount : driven by the mixer (slave)
interface mix_accum_clip_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int NCH   = 3,
  parameter int CNT_W = 8
);
  logic                iStart;
  logic [NCH*IN_W-1:0] iIn;
  logic [NCH-1:0]      iMask;
  logic                iClrClip;
  logic                oBusy;
  logic                oValid;
  logic [OUT_W-1:0]    oOut;
  logic                oClip;
  logic                oClipSticky;
  logic [CNT_W-1:0]    oClipCount;

  modport master (
    output iStart, iIn, iMask, iClrClip,
    input  oBusy, oValid, oOut, oClip, oClipSticky, oClipCount
  );

  modport slave (
    input  iStart, iIn, iMask, iClrClip,
    output oBusy, oValid, oOut, oClip, oClipSticky, oClipCount
  );
endinterface

// File: rtl/sat_narrow.sv
// sat_narrow: combinational arithmetic right shift followed by signed
// saturation from ACC_W to OUT_W bits.
//   iAcc  : signed ACC_W-bit input
//   oOut  : signed OUT_W-bit saturated result
//   oClip : 1 when a limit was applied (landing exactly on a limit is not a clip)
module sat_narrow
  import mix_pkg::*;
#(
  parameter int ACC_W = 19,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] iAcc,
  output logic signed [OUT_W-1:0] oOut,
  output logic                    oClip
);

  // Compare at a width that holds both the input and the limits.
  localparam int CW = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic signed [CW-1:0] HI = CW'(satHi(OUT_W));
  localparam logic signed [CW-1:0] LO = CW'(satLo(OUT_W));

  logic signed [ACC_W-1:0] shifted;
  logic signed [CW-1:0]    wide;

  // >>> on a signed operand floors toward minus infinity.
  always_comb begin
    shifted = iAcc >>> SHIFT;
    wide    = CW'(shifted);
    oClip   = 1'b0;
    oOut    = wide[OUT_W-1:0];
    if (wide > HI) begin
      oOut  = HI[OUT_W-1:0];
      oClip = 1'b1;
    end else if (wide < LO) begin
      oOut  = LO[OUT_W-1:0];
      oClip = 1'b1;
    end
  end

endmodule

// File: rtl/mix_accum_clip.sv
// mix_accum_clip: time-multiplexed NCH-channel saturating mixer.
//   iClk, iRst : clock, asynchronous active-high reset
//   bus        : mix_accum_clip_if.slave (start/samples/mask/clear in,
//                busy/valid/result/clip flags/clip counter out)
// A start in IDLE captures the samples and mask, one channel is added per
// clock, and the saturated result appears with a one-cycle oValid in SAT.
module mix_accum_clip
  import mix_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int NCH   = 3,
  parameter int SHIFT = 0,
  parameter int CNT_W = 8
) (
  input  logic            iClk,
  input  logic            iRst,
  mix_accum_clip_if.slave bus
);

  localparam int ACC_W = accWidth(IN_W, NCH);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_t                  state, nextState;
  logic [NCH*IN_W-1:0]     inQ;
  logic [NCH-1:0]          maskQ;
  logic signed [ACC_W-1:0] acc, accNext;
  logic [IDX_W-1:0]        idx;
  logic signed [IN_W-1:0]  chSel;
  logic                    lastCh;
  logic signed [OUT_W-1:0] satOut;
  logic                    satClip;
  logic [OUT_W-1:0]        outQ;
  logic                    clipQ, validQ, stickyQ;
  logic [CNT_W-1:0]        countQ;

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= nextState;
  end

  // Next state; starts outside IDLE are simply dropped.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.iStart) nextState = ACCUM;
      ACCUM:   if (lastCh) nextState = SAT;
      SAT:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Channel select and running sum. The result is saturated from accNext so
  // it is registered on entry to SAT and is visible while oValid is high.
  always_comb begin
    chSel = '0;
    if (maskQ[idx]) chSel = inQ[int'(idx)*IN_W +: IN_W];
    accNext = acc + ACC_W'(chSel);
    lastCh  = (idx == IDX_W'(NCH - 1));
  end

  sat_narrow #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_sat (
    .iAcc (accNext),
    .oOut (satOut),
    .oClip(satClip)
  );

  // Capture, accumulation, result registers and clip bookkeeping. A clear
  // in the same SAT cycle as a clip still records that clip.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      inQ     <= '0;
      maskQ   <= '0;
      acc     <= '0;
      idx     <= '0;
      outQ    <= '0;
      clipQ   <= 1'b0;
      validQ  <= 1'b0;
      stickyQ <= 1'b0;
      countQ  <= '0;
    end else begin
      validQ <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iStart) begin
            inQ   <= bus.iIn;
            maskQ <= bus.iMask;
            acc   <= '0;
            idx   <= '0;
          end
        end
        ACCUM: begin
          acc <= accNext;
          idx <= idx + IDX_W'(1);
          if (lastCh) begin
            outQ   <= satOut;
            clipQ  <= satClip;
            validQ <= 1'b1;
          end
        end
        default: ;
      endcase

      if (state == SAT && clipQ) begin
        stickyQ <= 1'b1;
        if (bus.iClrClip)        countQ <= CNT_W'(1);
        else if (countQ != '1)   countQ <= countQ + CNT_W'(1);
      end else if (bus.iClrClip) begin
        stickyQ <= 1'b0;
        countQ  <= '0;
      end
    end
  end

  assign bus.oBusy       = (state != IDLE);
  assign bus.oValid      = validQ;
  assign bus.oOut        = outQ;
  assign bus.oClip       = clipQ;
  assign bus.oClipSticky = stickyQ;
  assign bus.oClipCount  = countQ;

endmodule

// File: tb/tb_mix_accum_clip.sv
// tb_mix_accum_clip: scoreboard bench for mix_accum_clip. dut0 uses SHIFT=0,
// dut1 uses SHIFT=1. Stimulus pushes the expected result; per-DUT monitors
// pop and compare on every oValid, then check sticky/count one cycle later.
module tb_mix_accum_clip;

  logic iClk;
  logic iRst;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [15:0] out;
    logic        clip;
    logic        sticky;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  mix_accum_clip_if #(.IN_W(16), .OUT_W(16), .NCH(3), .CNT_W(8)) bus0 ();
  mix_accum_clip_if #(.IN_W(16), .OUT_W(16), .NCH(3), .CNT_W(8)) bus1 ();

  mix_accum_clip #(.IN_W(16), .OUT_W(16), .NCH(3), .SHIFT(0), .CNT_W(8)) dut0 (
    .iClk(iClk), .iRst(iRst), .bus(bus0)
  );
  mix_accum_clip #(.IN_W(16), .OUT_W(16), .NCH(3), .SHIFT(1), .CNT_W(8)) dut1 (
    .iClk(iClk), .iRst(iRst), .bus(bus1)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Issue one mix on dut0 (sel=0) or dut1 (sel=1), push its expected result
  // and wait for completion; optionally pulse iClrClip in the SAT cycle.
  task automatic applyStimulus(input bit sel, input logic [15:0] c2, input logic [15:0] c1,
                               input logic [15:0] c0, input logic [2:0] m,
                               input logic [15:0] eOut, input logic eClip,
                               input logic eSticky, input logic [7:0] eCnt,
                               input bit clrAtSat);
    exp_t e;
    bit   done;
    e.out = eOut; e.clip = eClip; e.sticky = eSticky; e.cnt = eCnt;
    @(negedge iClk);
    if (!sel) begin
      bus0.iIn = {c2, c1, c0}; bus0.iMask = m; bus0.iStart = 1'b1; q0.push_back(e);
    end else begin
      bus1.iIn = {c2, c1, c0}; bus1.iMask = m; bus1.iStart = 1'b1; q1.push_back(e);
    end
    @(negedge iClk);
    bus0.iStart = 1'b0;
    bus1.iStart = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if ((sel ? bus1.oValid : bus0.oValid) === 1'b1) done = 1'b1;
      else @(negedge iClk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL oValid timeout: got none expected pulse within 20 cycles");
    end
    if (clrAtSat) bus0.iClrClip = 1'b1;
    @(negedge iClk);
    bus0.iClrClip = 1'b0;
  endtask

  // dut0 monitor
  initial begin
    exp_t m;
    forever begin
      @(negedge iClk);
      if (bus0.oValid === 1'b1) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL dut0 unexpected oValid: got 1 expected 0");
        end else begin
          m = q0.pop_front();
          checkOutput("dut0 oOut", 32'(bus0.oOut), 32'(m.out));
          checkOutput("dut0 oClip", 32'(bus0.oClip), 32'(m.clip));
          @(negedge iClk);
          checkOutput("dut0 oClipSticky", 32'(bus0.oClipSticky), 32'(m.sticky));
          checkOutput("dut0 oClipCount", 32'(bus0.oClipCount), 32'(m.cnt));
        end
      end
    end
  end

  // dut1 monitor
  initial begin
    exp_t m;
    forever begin
      @(negedge iClk);
      if (bus1.oValid === 1'b1) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL dut1 unexpected oValid: got 1 expected 0");
        end else begin
          m = q1.pop_front();
          checkOutput("dut1 oOut", 32'(bus1.oOut), 32'(m.out));
          checkOutput("dut1 oClip", 32'(bus1.oClip), 32'(m.clip));
          @(negedge iClk);
          checkOutput("dut1 oClipSticky", 32'(bus1.oClipSticky), 32'(m.sticky));
          checkOutput("dut1 oClipCount", 32'(bus1.oClipCount), 32'(m.cnt));
        end
      end
    end
  end

  initial begin
    exp_t e;
    iRst = 1'b1;
    bus0.iStart = 1'b0; bus0.iIn = '0; bus0.iMask = '0; bus0.iClrClip = 1'b0;
    bus1.iStart = 1'b0; bus1.iIn = '0; bus1.iMask = '0; bus1.iClrClip = 1'b0;
    #12;
    checkOutput("reset oBusy", 32'(bus0.oBusy), 32'd0);
    checkOutput("reset oValid", 32'(bus0.oValid), 32'd0);
    checkOutput("reset oOut", 32'(bus0.oOut), 32'd0);
    checkOutput("reset oClip", 32'(bus0.oClip), 32'd0);
    checkOutput("reset oClipSticky", 32'(bus0.oClipSticky), 32'd0);
    checkOutput("reset oClipCount", 32'(bus0.oClipCount), 32'd0);
    @(negedge iClk);
    iRst = 1'b0;

    // Basic mix with latency/busy timeline; inputs scrambled after capture.
    $display("[TB] basic mix");
    @(negedge iClk);
    bus0.iIn = {16'h03E8, 16'h07D0, 16'hFE0C}; bus0.iMask = 3'b111; bus0.iStart = 1'b1;
    e.out = 16'h09C4; e.clip = 1'b0; e.sticky = 1'b0; e.cnt = 8'd0;
    q0.push_back(e);
    for (int c = 1; c <= 5; c++) begin
      @(negedge iClk);
      if (c == 1) begin
        bus0.iStart = 1'b0; bus0.iIn = '1; bus0.iMask = 3'b000;
      end
      checkOutput($sformatf("T1 oBusy cycle %0d", c), 32'(bus0.oBusy), (c <= 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("T1 oValid cycle %0d", c), 32'(bus0.oValid), (c == 4) ? 32'd1 : 32'd0);
    end

    $display("[TB] clips, mask, limits");
    applyStimulus(0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 3'b111, 16'h7FFF, 1, 1, 8'd1, 0);
    applyStimulus(0, 16'h8000, 16'h8000, 16'h8000, 3'b111, 16'h8000, 1, 1, 8'd2, 0);
    applyStimulus(0, 16'h7FFF, 16'h0005, 16'h7FFF, 3'b010, 16'h0005, 0, 1, 8'd2, 0);
    repeat (3) @(negedge iClk);
    checkOutput("oOut holds", 32'(bus0.oOut), 32'h0005);
    applyStimulus(0, 16'h0000, 16'h0000, 16'h7FFF, 3'b111, 16'h7FFF, 0, 1, 8'd2, 0);
    applyStimulus(0, 16'h0000, 16'h0000, 16'h8000, 3'b111, 16'h8000, 0, 1, 8'd2, 0);
    applyStimulus(0, 16'h012C, 16'h00C8, 16'h0064, 3'b000, 16'h0000, 0, 1, 8'd2, 0);
    applyStimulus(0, 16'h0000, 16'h0001, 16'h7FFF, 3'b111, 16'h7FFF, 1, 1, 8'd3, 0);

    $display("[TB] shift by one");
    applyStimulus(1, 16'h0000, 16'h0000, 16'hFFFD, 3'b111, 16'hFFFE, 0, 0, 8'd0, 0);
    applyStimulus(1, 16'h0000, 16'h7FFF, 16'h7FFF, 3'b011, 16'h7FFF, 0, 0, 8'd0, 0);
    applyStimulus(1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 3'b111, 16'h7FFF, 1, 1, 8'd1, 0);

    // Starts during ACCUM and SAT must be ignored.
    $display("[TB] start hazards");
    @(negedge iClk);
    bus0.iIn = {16'd30, 16'd20, 16'd10}; bus0.iMask = 3'b111; bus0.iStart = 1'b1;
    e.out = 16'd60; e.clip = 1'b0; e.sticky = 1'b1; e.cnt = 8'd3;
    q0.push_back(e);
    for (int c = 1; c <= 8; c++) begin
      @(negedge iClk);
      bus0.iStart = (c == 2 || c == 4);
      if (c == 2) bus0.iIn = {16'd1, 16'd1, 16'd1};
      if (c >= 5) checkOutput($sformatf("hazard oBusy cycle %0d", c), 32'(bus0.oBusy), 32'd0);
    end

    // Reset in the middle of ACCUM.
    $display("[TB] reset mid-mix");
    @(negedge iClk);
    bus0.iIn = {16'h7FFF, 16'h7FFF, 16'h7FFF}; bus0.iMask = 3'b111; bus0.iStart = 1'b1;
    @(negedge iClk);
    bus0.iStart = 1'b0;
    @(negedge iClk);
    #1 iRst = 1'b1;
    #1;
    checkOutput("midreset oBusy", 32'(bus0.oBusy), 32'd0);
    checkOutput("midreset oValid", 32'(bus0.oValid), 32'd0);
    checkOutput("midreset oOut", 32'(bus0.oOut), 32'd0);
    checkOutput("midreset oClip", 32'(bus0.oClip), 32'd0);
    checkOutput("midreset oClipSticky", 32'(bus0.oClipSticky), 32'd0);
    checkOutput("midreset oClipCount", 32'(bus0.oClipCount), 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    repeat (8) @(negedge iClk);
    checkOutput("post reset oBusy", 32'(bus0.oBusy), 32'd0);

    $display("[TB] clip bookkeeping");
    applyStimulus(0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 3'b111, 16'h7FFF, 1, 1, 8'd1, 0);
    applyStimulus(0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 3'b111, 16'h7FFF, 1, 1, 8'd1, 1);
    for (int k = 1; k <= 300; k++) begin
      applyStimulus(0, 16'h8000, 16'h8000, 16'h8000, 3'b111, 16'h8000, 1, 1,
                    8'((1 + k > 255) ? 255 : (1 + k)), 0);
    end
    @(negedge iClk);
    bus0.iClrClip = 1'b1;
    @(negedge iClk);
    bus0.iClrClip = 1'b0;
    checkOutput("lone clear oClipSticky", 32'(bus0.oClipSticky), 32'd0);
    checkOutput("lone clear oClipCount", 32'(bus0.oClipCount), 32'd0);
    checkOutput("lone clear oOut holds", 32'(bus0.oOut), 32'h8000);

    repeat (10) @(negedge iClk);
    checkOutput("dut0 queue drained", 32'(q0.size()), 32'd0);
    checkOutput("dut1 queue drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
